id_probe: RTL and testbench

- Bus initiator that drives the native CPU peripheral interface (valid/address/wstrb/rdata/ready) from the master side.
- On a start pulse it reads the ID register of N_SLOTS consecutive peripheral addresses and latches each returned word plus a responded/timed-out flag.
- Sits in the SoC boot/self-test path, alongside or in place of CPU accesses, to enumerate which peripherals are present.

---
 rtl/id_probe.sv | 155 +++++++++++++++
 tb/tb_id_probe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_probe.sv
// id_probe: native-bus initiator that enumerates peripherals by reading the
// ID word of slots 0..N_SLOTS-1. Each slot either answers within TIMEOUT
// request cycles or is recorded as absent. Results stay readable until the
// next accepted start.
module id_probe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int N_SLOTS = 4,
    parameter int TIMEOUT = 15,
    localparam int RES_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int NP_W   = $clog2(N_SLOTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               m_valid,
    output logic [ADDR_W-1:0]  m_address,
    output logic               m_wstrb,
    input  logic [DATA_W-1:0]  m_rdata,
    input  logic               m_ready,
    input  logic [RES_W-1:0]   res_idx,
    output logic [DATA_W-1:0]  res_data,
    output logic [N_SLOTS-1:0] present,
    output logic [NP_W-1:0]    n_present
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(N_SLOTS - 1);
    localparam logic [ADDR_W-1:0] SLOT_ONE  = ADDR_W'(1);
    localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0]        CNT_ONE   = 8'd1;
    localparam logic [NP_W-1:0]   NP_ONE    = NP_W'(1);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_slot;
    logic [7:0]         r_cnt;
    logic [DATA_W-1:0]  r_result [N_SLOTS];
    logic [N_SLOTS-1:0] r_present;
    logic [NP_W-1:0]    r_n_present;

    logic [RES_W-1:0]   w_slot_idx;
    logic [DATA_W-1:0]  w_res_tab [2**RES_W];

    // The slot counter never exceeds N_SLOTS-1, so its low bits index the result array.
    assign w_slot_idx = r_slot[RES_W-1:0];

    // Scan sequencer: one request per slot, a one-cycle idle gap between slots
    // so that the responder's held ready can never be mistaken for a new answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_slot      <= '0;
            r_cnt       <= '0;
            r_present   <= '0;
            r_n_present <= '0;
            // NOTE: the result store is cleared by reset because an absent slot must
            // read back as zero; a plain data buffer would normally not be reset.
            for (int i = 0; i < N_SLOTS; i++) begin
                r_result[i] <= '0;
            end
        end else begin
            // NOTE: every state register uses non-blocking assignment so all of them
            // see the same pre-edge values regardless of statement order.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_REQ;
                        r_busy      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_slot      <= '0;
                        r_cnt       <= '0;
                        r_present   <= '0;
                        r_n_present <= '0;
                        for (int i = 0; i < N_SLOTS; i++) begin
                            r_result[i] <= '0;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    // An answer in the last allowed cycle still wins over the timeout.
                    if (m_ready) begin
                        r_result[w_slot_idx]  <= m_rdata;
                        r_present[w_slot_idx] <= 1'b1;
                        r_n_present           <= r_n_present + NP_ONE;
                        r_valid               <= 1'b0;
                        r_state               <= S_GAP;
                    end else if (r_cnt == TO_LAST) begin
                        r_result[w_slot_idx]  <= '0;
                        r_present[w_slot_idx] <= 1'b0;
                        r_valid               <= 1'b0;
                        r_state               <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_cnt <= '0;
                    if (r_slot == LAST_SLOT) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_slot  <= r_slot + SLOT_ONE;
                        r_valid <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Read-back table padded to a power of two; selects past the last slot return zero.
    genvar g;
    generate
        for (g = 0; g < 2**RES_W; g++) begin : g_tab
            if (g < N_SLOTS) begin : g_slot
                assign w_res_tab[g] = r_result[g];
            end else begin : g_pad
                assign w_res_tab[g] = '0;
            end
        end
    endgenerate

    assign res_data  = w_res_tab[res_idx];
    assign busy      = r_busy;
    assign done      = r_done;
    assign m_valid   = r_valid;
    assign m_address = r_slot;
    assign m_wstrb   = 1'b0;
    assign present   = r_present;
    assign n_present = r_n_present;

endmodule

// File: tb/tb_id_probe.sv
// tb_id_probe: bench for id_probe. Bus responders are modelled per slot with a
// configurable answer latency; the expected bus timeline and final results of
// each scan are derived from those latencies and checked every cycle.
module tb_id_probe;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int N_SLOTS = 4;
    localparam int TIMEOUT = 15;
    localparam int RES_W   = 2;
    localparam int NP_W    = 3;
    localparam int NEVER   = 255;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic               m_valid;
    logic [ADDR_W-1:0]  m_address;
    logic               m_wstrb;
    logic [DATA_W-1:0]  m_rdata = '0;
    logic               m_ready = 1'b0;
    logic [RES_W-1:0]   res_idx = '0;
    logic [DATA_W-1:0]  res_data;
    logic [N_SLOTS-1:0] present;
    logic [NP_W-1:0]    n_present;

    id_probe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_SLOTS(N_SLOTS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .m_valid  (m_valid),
        .m_address(m_address),
        .m_wstrb  (m_wstrb),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .res_idx  (res_idx),
        .res_data (res_data),
        .present  (present),
        .n_present(n_present)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- responder model ----------------
    int                cfg_lat [N_SLOTS];
    logic [DATA_W-1:0] cfg_id  [N_SLOTS];
    logic              noise = 1'b0;
    logic              smp_valid = 1'b0;
    logic [ADDR_W-1:0] smp_addr = '0;
    int                vcnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            smp_valid = m_valid;
            smp_addr  = m_address;
        end
    end

    // Registered ready: after cfg_lat consecutive sampled valid cycles, held one cycle after valid drops.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                vcnt    = 0;
                m_ready = 1'b0;
            end else if (smp_valid && (smp_addr < N_SLOTS)) begin
                vcnt++;
                m_ready = (vcnt >= cfg_lat[smp_addr]);
                m_rdata = cfg_id[smp_addr];
            end else begin
                vcnt    = 0;
                m_ready = noise;
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t              exp_q [$];
    logic [N_SLOTS-1:0] mdl_present = '0;
    int                mdl_np = 0;
    logic [DATA_W-1:0] mdl_res [N_SLOTS];

    function automatic void push_exp(input logic v, input int a, input logic b, input logic d);
        exp_t e;
        e.valid = v;
        e.addr  = ADDR_W'(a);
        e.busy  = b;
        e.done  = d;
        exp_q.push_back(e);
    endfunction

    // Slot i holds the bus lat+1 cycles when it answers in time, else TIMEOUT cycles, then one idle cycle.
    function automatic int plan_scan();
        bit acc;
        int dur;
        exp_q.delete();
        for (int i = 0; i < N_SLOTS; i++) begin
            acc = (cfg_lat[i] <= TIMEOUT - 1);
            dur = acc ? cfg_lat[i] + 1 : TIMEOUT;
            for (int c = 0; c < dur; c++) push_exp(1'b1, i, 1'b1, 1'b0);
            push_exp(1'b0, i, 1'b1, 1'b0);
            mdl_present[i] = acc;
            mdl_res[i]     = acc ? cfg_id[i] : '0;
        end
        push_exp(1'b0, 0, 1'b1, 1'b1);
        mdl_np = $countones(mdl_present);
        return exp_q.size();
    endfunction

    function automatic void clear_model();
        exp_q.delete();
        mdl_present = '0;
        mdl_np      = 0;
        for (int i = 0; i < N_SLOTS; i++) mdl_res[i] = '0;
    endfunction

    // Per-cycle compare against the planned timeline; idle cycles also check held results.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("wstrb", m_wstrb, 1'b0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cyc_valid", m_valid, e.valid);
                check("cyc_busy", busy, e.busy);
                check("cyc_done", done, e.done);
                if (e.valid) check("cyc_addr", m_address, e.addr);
            end else begin
                check("idle_valid", m_valid, 1'b0);
                check("idle_busy", busy, 1'b0);
                check("idle_done", done, 1'b0);
                check("idle_present", present, mdl_present);
                check("idle_n_present", n_present, mdl_np);
                check("idle_res_data", res_data, mdl_res[res_idx]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            res_idx = RES_W'($urandom_range(0, N_SLOTS - 1));
            noise   = 1'($urandom_range(0, 1));
        end
    endtask

    // Starts a scan; ign_at > 0 pulses start again during that cycle of the scan (must be ignored).
    task automatic run_scan(input int ign_at, output int done_cyc);
        int total;
        bit seen;
        @(negedge clk);
        noise = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total = plan_scan();
        seen = 1'b0;
        done_cyc = 0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                done_cyc = k;
            end
            if (k == ign_at) start = 1'b1;
        end
        if (start) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("done_seen", seen, 1'b1);
        check("done_cycle", done_cyc, total);
    endtask

    task automatic check_final(input logic [N_SLOTS-1:0] exp_p, input int exp_np);
        @(posedge clk);
        #2;
        check("lit_present", present, exp_p);
        check("lit_n_present", n_present, exp_np);
    endtask

    task automatic check_res(input int idx, input logic [DATA_W-1:0] lit);
        @(posedge clk);
        #2;
        res_idx = RES_W'(idx);
        #1;
        check("lit_res_data", res_data, lit);
    endtask

    task automatic set_all_fast();
        for (int i = 0; i < N_SLOTS; i++) begin
            cfg_lat[i] = 1;
            cfg_id[i]  = 32'hA0 + DATA_W'(i);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dc;
        int r;
        int ign;
        set_all_fast();
        clear_model();

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_addr", m_address, 0);
        check("rst_present", present, 0);
        check("rst_n_present", n_present, 0);
        check("rst_res_data", res_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        idle_cycles(3);

        // All four responders answer with one-cycle latency.
        set_all_fast();
        run_scan(0, dc);
        check("a_done_cycle", dc, 13);
        check_final(4'b1111, 4);
        check_res(0, 32'hA0);
        check_res(1, 32'hA1);
        check_res(2, 32'hA2);
        check_res(3, 32'hA3);
        idle_cycles(2);

        // Slot 2 never answers.
        set_all_fast();
        cfg_lat[2] = NEVER;
        run_scan(0, dc);
        check("b_done_cycle", dc, 26);
        check_final(4'b1011, 3);
        check_res(2, 32'h0);
        check_res(3, 32'hA3);
        idle_cycles(2);

        // Slot 1 answers on the last allowed request cycle.
        set_all_fast();
        cfg_lat[1] = TIMEOUT - 1;
        cfg_id[1]  = 32'h1234_5678;
        run_scan(0, dc);
        check("c_done_cycle", dc, 26);
        check_final(4'b1111, 4);
        check_res(1, 32'h1234_5678);
        idle_cycles(2);

        // Slot 1 answers one cycle too late.
        set_all_fast();
        cfg_lat[1] = TIMEOUT;
        run_scan(0, dc);
        check("c2_done_cycle", dc, 26);
        check_final(4'b1101, 3);
        check_res(1, 32'h0);
        idle_cycles(2);

        // Start repeated while busy, and again in the done cycle: both ignored.
        set_all_fast();
        run_scan(3, dc);
        check("d_done_cycle", dc, 13);
        idle_cycles(1);
        run_scan(13, dc);
        check("d2_done_cycle", dc, 13);
        idle_cycles(3);

        // Every slot silent: previous results must be cleared.
        for (int i = 0; i < N_SLOTS; i++) cfg_lat[i] = NEVER;
        run_scan(0, dc);
        check("e_done_cycle", dc, 4 * (TIMEOUT + 1) + 1);
        check_final(4'b0000, 0);
        check_res(0, 32'h0);
        idle_cycles(2);

        // Reset while requesting slot 1.
        set_all_fast();
        @(negedge clk);
        noise = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        r = plan_scan();
        repeat (4) @(negedge clk);
        check("f_pre_valid", m_valid, 1'b1);
        check("f_pre_addr", m_address, 1);
        check("f_pre_present", present, 4'b0001);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("f_rst_valid", m_valid, 1'b0);
        check("f_rst_busy", busy, 1'b0);
        check("f_rst_present", present, 0);
        check("f_rst_n_present", n_present, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        idle_cycles(6);

        // Randomized scans.
        for (int s = 0; s < 25; s++) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 5)      cfg_lat[i] = int'($urandom_range(1, 3));
                else if (r < 8) cfg_lat[i] = int'($urandom_range(12, 16));
                else            cfg_lat[i] = NEVER;
                cfg_id[i] = $urandom;
            end
            ign = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            run_scan(ign, dc);
            idle_cycles(int'($urandom_range(1, 4)));
        end

        idle_cycles(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
